// File: rtl/dcache_writeback_buffer_pkg.sv
// Shared types and width helpers for the data-cache write-back buffer.
package dcache_writeback_buffer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } wb_state_e;

  localparam int FIFO_DEPTH = 2;

  function automatic int calc_line_bits(input int offset_bits);
    return 8 * (1 << offset_bits);
  endfunction

  function automatic int calc_tag_bits(input int addr_width, input int offset_bits,
                                       input int index_bits);
    return addr_width - offset_bits - index_bits;
  endfunction

  function automatic int calc_beats(input int offset_bits, input int burst_width);
    return calc_line_bits(offset_bits) / burst_width;
  endfunction

  function automatic int calc_beat_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/dcache_writeback_buffer_wb_fifo.sv
// Two-entry FIFO of evicted lines; both entries are exposed so the fill path
// can check for a pending write-back of the line it is about to fetch.
module dcache_writeback_buffer_wb_fifo #(
  parameter int TAG_BITS   = 19,
  parameter int INDEX_BITS = 8,
  parameter int LINE_BITS  = 256,
  localparam int KEY_BITS  = TAG_BITS + INDEX_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [TAG_BITS-1:0]      push_tag,
  input  logic [INDEX_BITS-1:0]    push_index,
  input  logic [LINE_BITS-1:0]     push_line,
  output logic [TAG_BITS-1:0]      head_tag,
  output logic [INDEX_BITS-1:0]    head_index,
  output logic [LINE_BITS-1:0]     head_line,
  output logic [1:0]               count,
  output logic [1:0]               entry_valid,
  output logic [1:0][KEY_BITS-1:0] entry_key
);

  logic [TAG_BITS-1:0]   tag_mem   [2];
  logic [INDEX_BITS-1:0] index_mem [2];
  logic [LINE_BITS-1:0]  line_mem  [2];

  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload is never reset: validity is carried entirely by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr_reg]   <= push_tag;
      index_mem[wr_ptr_reg] <= push_index;
      line_mem[wr_ptr_reg]  <= push_line;
    end
  end

  assign head_tag   = tag_mem[rd_ptr_reg];
  assign head_index = index_mem[rd_ptr_reg];
  assign head_line  = line_mem[rd_ptr_reg];
  assign count      = count_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      assign entry_valid[gi] = (count_reg == 2'd2) ||
                               ((count_reg == 2'd1) && (rd_ptr_reg == 1'(gi)));
      assign entry_key[gi]   = {tag_mem[gi], index_mem[gi]};
    end
  endgenerate

endmodule

// File: rtl/dcache_writeback_buffer.sv
// Write-back buffer: queues dirty victim lines and streams each one to memory
// as a BEATS-long burst, while answering fill-path lookups against queued lines.
module dcache_writeback_buffer
  import dcache_writeback_buffer_pkg::*;
#(
  parameter int OFFSET_BITS = 5,
  parameter int INDEX_BITS  = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int BURST_WIDTH = 64,
  localparam int TAG_BITS   = calc_tag_bits(ADDR_WIDTH, OFFSET_BITS, INDEX_BITS),
  localparam int LINE_BITS  = calc_line_bits(OFFSET_BITS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   evict_valid,
  output logic                   evict_ready,
  input  logic [TAG_BITS-1:0]    evict_tag,
  input  logic [INDEX_BITS-1:0]  evict_index,
  input  logic [LINE_BITS-1:0]   evict_data,
  output logic [ADDR_WIDTH-1:0]  pmem_address,
  output logic [BURST_WIDTH-1:0] pmem_wdata,
  output logic                   pmem_write,
  input  logic                   pmem_resp,
  input  logic [ADDR_WIDTH-1:0]  lookup_address,
  output logic                   lookup_hit,
  output logic                   empty
);

  localparam int BEATS    = calc_beats(OFFSET_BITS, BURST_WIDTH);
  localparam int BEAT_W   = calc_beat_w(BEATS);
  localparam int KEY_BITS = TAG_BITS + INDEX_BITS;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  wb_state_e state_reg, state_next;
  logic [BEAT_W-1:0] beat_reg, beat_next;
  logic gap_reg, gap_next;

  logic                   push, pop;
  logic                   beat_ack, last_beat, entries_remain;
  logic [TAG_BITS-1:0]    head_tag;
  logic [INDEX_BITS-1:0]  head_index;
  logic [LINE_BITS-1:0]   head_line;
  logic [1:0]             fifo_count;
  logic [1:0]             entry_valid;
  logic [1:0][KEY_BITS-1:0] entry_key;
  logic [1:0]             hit_vec;
  logic [KEY_BITS-1:0]    lookup_key;
  logic [OFFSET_BITS-1:0] lookup_offset_unused;

  dcache_writeback_buffer_wb_fifo #(
    .TAG_BITS   (TAG_BITS),
    .INDEX_BITS (INDEX_BITS),
    .LINE_BITS  (LINE_BITS)
  ) wb_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .push_tag    (evict_tag),
    .push_index  (evict_index),
    .push_line   (evict_data),
    .head_tag    (head_tag),
    .head_index  (head_index),
    .head_line   (head_line),
    .count       (fifo_count),
    .entry_valid (entry_valid),
    .entry_key   (entry_key)
  );

  assign evict_ready = (fifo_count < 2'd2);
  assign push        = evict_valid && evict_ready;

  assign pmem_write  = (state_reg == ST_BURST) && !gap_reg;
  assign beat_ack    = pmem_write && pmem_resp;
  assign last_beat   = beat_ack && (beat_reg == BEAT_LAST);
  assign pop         = last_beat;
  // A final-beat pop leaves work behind if the FIFO was full or refilled this cycle.
  assign entries_remain = (fifo_count == 2'd2) || push;

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    gap_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if ((fifo_count != 2'd0) || push) state_next = ST_BURST;
      end
      ST_BURST: begin
        if (beat_ack) begin
          beat_next = last_beat ? '0 : beat_reg + 1'b1;
        end
        // Between consecutive lines the request is withdrawn for one cycle.
        if (last_beat) begin
          if (entries_remain) gap_next   = 1'b1;
          else                state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      beat_reg  <= '0;
      gap_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      gap_reg   <= gap_next;
    end
  end

  assign pmem_address = {head_tag, head_index, {OFFSET_BITS{1'b0}}};
  assign pmem_wdata   = head_line[beat_reg*BURST_WIDTH +: BURST_WIDTH];

  assign lookup_key           = lookup_address[ADDR_WIDTH-1:OFFSET_BITS];
  assign lookup_offset_unused = lookup_address[OFFSET_BITS-1:0];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lookup
      assign hit_vec[gi] = entry_valid[gi] && (entry_key[gi] == lookup_key);
    end
  endgenerate

  assign lookup_hit = |hit_vec;
  assign empty      = (fifo_count == 2'd0) && (state_reg == ST_IDLE);

endmodule

// File: tb/tb_dcache_writeback_buffer.sv
// Directed bench for the write-back buffer: a per-cycle vector table for the
// single-line burst and hand sequences for back-to-back, full, push-on-pop and reset.
module tb_dcache_writeback_buffer;

  localparam int TAG_W  = 19;
  localparam int IDX_W  = 8;
  localparam int LINE_W = 256;
  localparam int BW     = 64;
  localparam int BEATS  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              evict_valid = 1'b0;
  logic              evict_ready;
  logic [TAG_W-1:0]  evict_tag = '0;
  logic [IDX_W-1:0]  evict_index = '0;
  logic [LINE_W-1:0] evict_data = '0;
  logic [31:0]       pmem_address;
  logic [BW-1:0]     pmem_wdata;
  logic              pmem_write;
  logic              pmem_resp = 1'b0;
  logic [31:0]       lookup_address = '0;
  logic              lookup_hit;
  logic              empty;

  int passed = 0;
  int total  = 0;

  dcache_writeback_buffer #(
    .OFFSET_BITS (5),
    .INDEX_BITS  (8),
    .ADDR_WIDTH  (32),
    .BURST_WIDTH (64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .evict_valid    (evict_valid),
    .evict_ready    (evict_ready),
    .evict_tag      (evict_tag),
    .evict_index    (evict_index),
    .evict_data     (evict_data),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_write     (pmem_write),
    .pmem_resp      (pmem_resp),
    .lookup_address (lookup_address),
    .lookup_hit     (lookup_hit),
    .empty          (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [TAG_W-1:0] line_tag(input int id);
    return 19'h12345 ^ TAG_W'(id - 1);
  endfunction

  function automatic logic [IDX_W-1:0] line_idx(input int id);
    return 8'h3A + IDX_W'(id - 1);
  endfunction

  function automatic logic [31:0] line_addr(input int id);
    return {line_tag(id), line_idx(id), 5'b0};
  endfunction

  function automatic logic [BW-1:0] beat_val(input int id, input int k);
    return {8'(id), 8'(k), 48'h0123_4567_89AB};
  endfunction

  function automatic logic [LINE_W-1:0] line_data(input int id);
    logic [LINE_W-1:0] d;
    d = '0;
    for (int k = 0; k < BEATS; k++) d[k*BW +: BW] = beat_val(id, k);
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic offer(input int id);
    evict_valid = 1'b1;
    evict_tag   = line_tag(id);
    evict_index = line_idx(id);
    evict_data  = line_data(id);
  endtask

  // Memory model: holds off each beat for 'delay' write cycles, checks every
  // beat in order, and requires exactly one dead cycle between lines.
  task automatic drain(input int first, input int nlines, input int delay);
    int beat_no = 0;
    int wait_cnt = 0;
    int gap = 0;
    int cycles = 0;
    int id, k;
    bit measuring = 1'b0;
    int total_beats = nlines * BEATS;
    while (beat_no < total_beats && cycles < 400) begin
      if (pmem_write) begin
        if (measuring) begin
          chk("gap_cycles", 64'(gap), 64'd1);
          measuring = 1'b0;
        end
        if (wait_cnt == delay) begin
          pmem_resp = 1'b1;
          id = first + beat_no / BEATS;
          k  = beat_no % BEATS;
          #1;
          chk("beat_addr", 64'(pmem_address), 64'(line_addr(id)));
          chk("beat_wdata", pmem_wdata, beat_val(id, k));
          $display("beat line=%0d k=%0d addr=%h data=%h", id, k, pmem_address, pmem_wdata);
          beat_no++;
          wait_cnt = 0;
          if (k == BEATS - 1 && beat_no < total_beats) begin
            measuring = 1'b1;
            gap = 0;
          end
        end else begin
          pmem_resp = 1'b0;
          wait_cnt++;
          #1;
        end
      end else begin
        pmem_resp = 1'b0;
        wait_cnt = 0;
        if (measuring) gap++;
        #1;
      end
      @(negedge clk);
      cycles++;
    end
    pmem_resp = 1'b0;
    chk("drain_beats_done", 64'(beat_no), 64'(total_beats));
  endtask

  typedef struct {
    logic        ev;
    int          line_id;
    logic        resp;
    logic [31:0] laddr;
    logic        exp_ready;
    logic        exp_write;
    logic [31:0] exp_addr;
    int          exp_k;
    logic        exp_hit;
    logic        exp_empty;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // ev, id, resp, lookup, ready, write, addr, beat, hit, empty
    vecs[0] = '{1'b0, 0, 1'b0, 32'h2468A75C, 1'b1, 1'b0, 32'h0,        0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1, 1'b0, 32'h2468A75C, 1'b1, 1'b0, 32'h0,        0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 0, 1'b1, 32'h2468A75C, 1'b1, 1'b1, 32'h2468A740, 0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 0, 1'b1, 32'h2468A760, 1'b1, 1'b1, 32'h2468A740, 1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 0, 1'b1, 32'h2468A75C, 1'b1, 1'b1, 32'h2468A740, 2, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 0, 1'b1, 32'h2468A75C, 1'b1, 1'b1, 32'h2468A740, 3, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 0, 1'b1, 32'h2468A75C, 1'b1, 1'b0, 32'h0,        0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 0, 1'b0, 32'h2468A75C, 1'b1, 1'b0, 32'h0,        0, 1'b0, 1'b1};

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_ready", 64'(evict_ready), 64'd1);
    chk("rst_write", 64'(pmem_write), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_hit", 64'(lookup_hit), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single line, one response per cycle, with lookups
    for (int i = 0; i < 8; i++) begin
      evict_valid = vecs[i].ev;
      if (vecs[i].ev) offer(vecs[i].line_id);
      pmem_resp      = vecs[i].resp;
      lookup_address = vecs[i].laddr;
      #1;
      chk("vec_ready", 64'(evict_ready), 64'(vecs[i].exp_ready));
      chk("vec_write", 64'(pmem_write), 64'(vecs[i].exp_write));
      chk("vec_hit", 64'(lookup_hit), 64'(vecs[i].exp_hit));
      chk("vec_empty", 64'(empty), 64'(vecs[i].exp_empty));
      if (vecs[i].exp_write) begin
        chk("vec_addr", 64'(pmem_address), 64'(vecs[i].exp_addr));
        chk("vec_wdata", pmem_wdata, beat_val(1, vecs[i].exp_k));
      end
      $display("vec %0d write=%b addr=%h hit=%b empty=%b", i, pmem_write, pmem_address,
               lookup_hit, empty);
      @(negedge clk);
    end
    evict_valid = 1'b0;
    pmem_resp = 1'b0;
    lookup_address = '0;

    // Two lines back-to-back, slow memory
    offer(2);
    #1 chk("b2b_ready_first", 64'(evict_ready), 64'd1);
    @(negedge clk);
    offer(3);
    #1 chk("b2b_ready_second", 64'(evict_ready), 64'd1);
    chk("b2b_write_started", 64'(pmem_write), 64'd1);
    @(negedge clk);
    evict_valid = 1'b0;
    #1 chk("b2b_ready_full", 64'(evict_ready), 64'd0);
    drain(2, 2, 3);
    #1 chk("b2b_empty", 64'(empty), 64'd1);
    @(negedge clk);

    // Full buffer, push offered on the final-beat cycle
    offer(4);
    @(negedge clk);
    offer(5);
    @(negedge clk);
    evict_valid = 1'b0;
    pmem_resp = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("full_ready", 64'(evict_ready), 64'd0);
      chk("full_wdata", pmem_wdata, beat_val(4, k));
      @(negedge clk);
    end
    offer(6);
    #1 chk("final_beat_push_rejected", 64'(evict_ready), 64'd0);
    chk("final_beat_write", 64'(pmem_write), 64'd1);
    chk("final_beat_wdata", pmem_wdata, beat_val(4, 3));
    @(negedge clk);
    pmem_resp = 1'b0;
    #1 chk("full_gap_write", 64'(pmem_write), 64'd0);
    chk("full_retry_ready", 64'(evict_ready), 64'd1);
    @(negedge clk);
    evict_valid = 1'b0;
    #1 chk("full_count_two", 64'(evict_ready), 64'd0);
    chk("full_next_write", 64'(pmem_write), 64'd1);
    chk("full_next_addr", 64'(pmem_address), 64'(line_addr(5)));
    drain(5, 2, 0);
    #1 chk("full_empty", 64'(empty), 64'd1);
    @(negedge clk);

    // Push into a one-entry buffer on the final-beat cycle
    offer(7);
    @(negedge clk);
    evict_valid = 1'b0;
    pmem_resp = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("pp_wdata", pmem_wdata, beat_val(7, k));
      @(negedge clk);
    end
    offer(8);
    #1 chk("pp_ready", 64'(evict_ready), 64'd1);
    chk("pp_last_wdata", pmem_wdata, beat_val(7, 3));
    @(negedge clk);
    evict_valid = 1'b0;
    pmem_resp = 1'b0;
    lookup_address = line_addr(8) + 32'd5;
    #1 chk("pp_gap_write", 64'(pmem_write), 64'd0);
    chk("pp_gap_empty", 64'(empty), 64'd0);
    chk("pp_gap_hit", 64'(lookup_hit), 64'd1);
    @(negedge clk);
    #1 chk("pp_next_write", 64'(pmem_write), 64'd1);
    chk("pp_next_addr", 64'(pmem_address), 64'(line_addr(8)));
    drain(8, 1, 0);
    #1 chk("pp_empty", 64'(empty), 64'd1);
    chk("pp_hit_after_pop", 64'(lookup_hit), 64'd0);
    @(negedge clk);

    // Reset in the middle of a burst
    offer(9);
    lookup_address = line_addr(9) + 32'd4;
    @(negedge clk);
    evict_valid = 1'b0;
    pmem_resp = 1'b1;
    #1 chk("mid_write", 64'(pmem_write), 64'd1);
    chk("mid_hit", 64'(lookup_hit), 64'd1);
    @(negedge clk);
    @(negedge clk);
    pmem_resp = 1'b0;
    #1 chk("mid_beat2", pmem_wdata, beat_val(9, 2));
    rst = 1'b0;
    #1 chk("arst_write", 64'(pmem_write), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_ready", 64'(evict_ready), 64'd1);
    chk("arst_hit", 64'(lookup_hit), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    pmem_resp = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 chk("stray_write", 64'(pmem_write), 64'd0);
      chk("stray_empty", 64'(empty), 64'd1);
      @(negedge clk);
    end
    pmem_resp = 1'b0;
    offer(10);
    @(negedge clk);
    evict_valid = 1'b0;
    #1 chk("post_rst_addr", 64'(pmem_address), 64'(line_addr(10)));
    chk("post_rst_beat0", pmem_wdata, beat_val(10, 0));
    drain(10, 1, 0);
    #1 chk("post_rst_empty", 64'(empty), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
